dircc_receive_handler: RTL and testbench



---
 rtl/dircc_receive_handler_pkg.sv | 48 ++++
 rtl/dircc_receive_handler_if.sv | 33 +++
 rtl/dircc_sat_counter.sv | 24 ++
 rtl/dircc_receive_handler.sv | 166 ++++++++++++++++
 tb/tb_dircc_receive_handler.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dircc_receive_handler_pkg.sv
// Shared types for the DiRCC receive path: packet, tick message,
// device state and the receive FSM encoding.
package dircc_receive_handler_pkg;

  localparam int COUNT_W = 8;
  localparam int ID_W    = 16;
  localparam int USER_W  = 32;

  typedef logic [COUNT_W-1:0] count_t;

  typedef struct packed {
    logic            isDesignatedPacket;
    logic [ID_W-1:0] id;
  } tick_msg_t;

  typedef struct packed {
    logic   isDesignatedSender;
    count_t count;
  } dev_state_t;

  localparam int TICK_W = $bits(tick_msg_t);
  localparam int DEV_W  = $bits(dev_state_t);

  typedef struct packed {
    logic [15:0] dst;
    logic [15:0] src;
    logic [31:0] payload;
  } packet_data_t;

  typedef struct packed {
    logic [7:0]        dircc_state;
    logic [7:0]        dircc_state_extra;
    logic [USER_W-1:0] user_state;
  } device_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_READ_REQ,
    RX_READ_WAIT,
    RX_WRITE
  } dircc_rx_state_t;

  // Ids wider than the counter are truncated, narrower ones zero-extended.
  function automatic count_t id_to_count(logic [ID_W-1:0] id);
    return count_t'(id);
  endfunction

endpackage

// File: rtl/dircc_receive_handler_if.sv
// Ingress packet handshake plus device-state read/write bus
// shared between the receive handler and its neighbours.
interface dircc_receive_handler_if #(
  parameter int unsigned ADDRESS_MEM_WIDTH = 32
);
  import dircc_receive_handler_pkg::*;

  packet_data_t                 packet_in;
  logic                         packet_in_valid;
  logic                         packet_in_ready;
  logic [ADDRESS_MEM_WIDTH-1:0] read_addr;
  logic                         read_req;
  device_state_t                read_state;
  logic                         read_state_valid;
  logic [ADDRESS_MEM_WIDTH-1:0] write_addr;
  device_state_t                write_state;
  logic                         write_state_valid;

  modport master (
    output packet_in, packet_in_valid,
    output read_state, read_state_valid,
    input  packet_in_ready, read_addr, read_req,
    input  write_addr, write_state, write_state_valid
  );

  modport slave (
    input  packet_in, packet_in_valid,
    input  read_state, read_state_valid,
    output packet_in_ready, read_addr, read_req,
    output write_addr, write_state, write_state_valid
  );

endinterface

// File: rtl/dircc_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module dircc_sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dircc_receive_handler.sv
// Receive handler: accept a tick packet, read-modify-write the owning
// device's counter state, and keep drop/sequence/timeout statistics.
module dircc_receive_handler #(
  parameter int unsigned ADDRESS_MEM_WIDTH = 32,
  parameter              NODE_TYPE         = "default",
  parameter int          DEVICE_ID         = 0,
  parameter int unsigned READ_TIMEOUT      = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address,
  dircc_receive_handler_if.slave       rx,
  output logic [15:0]                  drop_count,
  output logic [15:0]                  seq_error_count,
  output logic [15:0]                  timeout_count
);
  import dircc_receive_handler_pkg::*;

  if (READ_TIMEOUT < 1 || READ_TIMEOUT > 65535 ||
      DEVICE_ID < 0 || $bits(NODE_TYPE) == 0) begin : g_bad_cfg
    $error("dircc_receive_handler: bad parameter set");
  end

  localparam logic [15:0] TMO = 16'(READ_TIMEOUT);

  dircc_rx_state_t              state_q;
  tick_msg_t                    msg_q;
  logic [ADDRESS_MEM_WIDTH-1:0] addr_q;
  logic [ADDRESS_MEM_WIDTH-1:0] waddr_q;
  device_state_t                wstate_q;
  logic                         rdy_q;
  logic                         rreq_q;
  logic                         wvalid_q;
  logic [15:0]                  wait_q;

  tick_msg_t  msg_in;
  logic       accept;
  logic       take;
  logic       rd_ok;
  logic       last_wait;
  logic       in_seq;
  dev_state_t dev_old;
  dev_state_t dev_new;
  logic       drop_inc;
  logic       seq_inc;
  logic       tmo_inc;
  logic       unused;

  assign msg_in = tick_msg_t'(rx.packet_in.payload[TICK_W-1:0]);
  assign accept = rx.packet_in_valid & rdy_q;
  assign take   = accept & msg_in.isDesignatedPacket;

  assign rd_ok     = (state_q == RX_READ_WAIT) & rx.read_state_valid;
  assign last_wait = (wait_q == TMO - 16'd1);

  always_comb begin
    dev_old = dev_state_t'(rx.read_state.user_state[DEV_W-1:0]);
    in_seq  = (id_to_count(msg_q.id) == dev_old.count);
    dev_new = dev_old;
    // Out-of-sequence ids resynchronise the counter to the sender's view.
    if (in_seq) begin
      dev_new.count = dev_old.count + count_t'(1);
    end else begin
      dev_new.count = id_to_count(msg_q.id) + count_t'(1);
    end
  end

  assign drop_inc = accept & ~msg_in.isDesignatedPacket;
  assign seq_inc  = rd_ok & ~in_seq;
  assign tmo_inc  = (state_q == RX_READ_WAIT) &
                    ~rx.read_state_valid & last_wait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      msg_q    <= '0;
      addr_q   <= '0;
      waddr_q  <= '0;
      wstate_q <= '0;
      rdy_q    <= 1'b0;
      rreq_q   <= 1'b0;
      wvalid_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      rreq_q   <= 1'b0;
      wvalid_q <= 1'b0;
      unique case (state_q)
        RX_IDLE: begin
          rdy_q <= ~take;
          if (take) begin
            msg_q   <= msg_in;
            addr_q  <= address;
            rreq_q  <= 1'b1;
            state_q <= RX_READ_REQ;
          end
        end
        RX_READ_REQ: begin
          wait_q  <= '0;
          state_q <= RX_READ_WAIT;
        end
        RX_READ_WAIT: begin
          // A valid on the final wait cycle still beats the timeout.
          if (rx.read_state_valid) begin
            wstate_q <= '{
              dircc_state:       rx.read_state.dircc_state,
              dircc_state_extra: rx.read_state.dircc_state_extra,
              user_state:        USER_W'(dev_new)
            };
            waddr_q  <= addr_q;
            wvalid_q <= 1'b1;
            state_q  <= RX_WRITE;
          end else if (last_wait) begin
            rdy_q   <= 1'b1;
            state_q <= RX_IDLE;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        RX_WRITE: begin
          rdy_q   <= 1'b1;
          state_q <= RX_IDLE;
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx.packet_in_ready   = rdy_q;
  assign rx.read_addr         = addr_q;
  assign rx.read_req          = rreq_q;
  assign rx.write_addr        = waddr_q;
  assign rx.write_state       = wstate_q;
  assign rx.write_state_valid = wvalid_q;

  dircc_sat_counter u_drop (
    .clk   (clk),
    .rst   (reset),
    .clr_i (1'b0),
    .inc_i (drop_inc),
    .cnt_o (drop_count)
  );

  dircc_sat_counter u_seq (
    .clk   (clk),
    .rst   (reset),
    .clr_i (1'b0),
    .inc_i (seq_inc),
    .cnt_o (seq_error_count)
  );

  dircc_sat_counter u_tmo (
    .clk   (clk),
    .rst   (reset),
    .clr_i (1'b0),
    .inc_i (tmo_inc),
    .cnt_o (timeout_count)
  );

  assign unused = ^{rx.packet_in.dst, rx.packet_in.src,
                    rx.packet_in.payload[31:TICK_W],
                    rx.read_state.user_state[USER_W-1:DEV_W]};

endmodule

// File: tb/tb_dircc_receive_handler.sv
// Directed and randomised bench for dircc_receive_handler against a
// memory-backed arithmetic model of the receive counter update.
module tb_dircc_receive_handler;
  import dircc_receive_handler_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 4;
  localparam int unsigned MOD = 2 ** COUNT_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic [15:0]   drop_count;
  logic [15:0]   seq_error_count;
  logic [15:0]   timeout_count;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  int exp_seq = 0;
  int exp_tmo = 0;
  int exp_wr = 0;
  int exp_rreq = 0;
  int wr_strobes = 0;
  int rreq_strobes = 0;

  device_state_t mem [int unsigned];

  dircc_receive_handler_if #(.ADDRESS_MEM_WIDTH(AW)) bus ();

  dircc_receive_handler #(
    .ADDRESS_MEM_WIDTH (AW),
    .NODE_TYPE         ("tb"),
    .DEVICE_ID         (3),
    .READ_TIMEOUT      (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .address         (address),
    .rx              (bus.slave),
    .drop_count      (drop_count),
    .seq_error_count (seq_error_count),
    .timeout_count   (timeout_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.write_state_valid === 1'b1) wr_strobes++;
    if (bus.read_req === 1'b1) rreq_strobes++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned addr_of(input int unsigned k);
    return 32'h100 + k * 32'h10;
  endfunction

  function automatic device_state_t rand_state();
    device_state_t s;
    s.dircc_state       = 8'($urandom);
    s.dircc_state_extra = 8'($urandom);
    s.user_state        = $urandom;
    return s;
  endfunction

  function automatic packet_data_t mk_pkt(input bit des,
                                          input int unsigned id);
    packet_data_t p;
    tick_msg_t    t;
    p.dst = 16'($urandom);
    p.src = 16'($urandom);
    p.payload = $urandom;
    t.isDesignatedPacket = des;
    t.id = 16'(id);
    p.payload[TICK_W-1:0] = t;
    return p;
  endfunction

  // Receive rule: stored count in user_state[7:0], sender flag in bit 8.
  function automatic device_state_t expect_write(input device_state_t old,
                                                 input int unsigned id);
    int unsigned   cnt;
    int unsigned   snd;
    int unsigned   nxt;
    device_state_t r;
    cnt = old.user_state % MOD;
    snd = (old.user_state / MOD) % 2;
    if ((id % 65536) % MOD == cnt) nxt = (cnt + 1) % MOD;
    else nxt = ((id % 65536) + 1) % MOD;
    r = old;
    r.user_state = snd * MOD + nxt;
    return r;
  endfunction

  task automatic rx_pkt(input int unsigned addr, input int unsigned id,
                        input int lat, input bit early);
    device_state_t exp;
    bit            mis;
    exp = expect_write(mem[addr], id);
    mis = ((id % 65536) % MOD) != (mem[addr].user_state % MOD);
    chk("ready_c0", bus.packet_in_ready, 1);
    address = addr;
    bus.packet_in = mk_pkt(1'b1, id);
    bus.packet_in_valid = 1'b1;
    @(negedge clk);
    bus.packet_in_valid = 1'b0;
    address = $urandom;
    exp_rreq++;
    chk("rreq_c1", bus.read_req, 1);
    chk("raddr_c1", bus.read_addr, addr);
    chk("ready_c1", bus.packet_in_ready, 0);
    if (early) begin
      bus.read_state = rand_state();
      bus.read_state_valid = 1'b1;
    end
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      bus.read_state_valid = 1'b0;
      if (i == 1) chk("rreq_c2", bus.read_req, 0);
      chk("ready_wait", bus.packet_in_ready, 0);
      if (i == lat) begin
        bus.read_state = mem[addr];
        bus.read_state_valid = 1'b1;
      end
    end
    @(negedge clk);
    bus.read_state_valid = 1'b0;
    bus.read_state = rand_state();
    if (mis) exp_seq++;
    exp_wr++;
    chk("wvalid", bus.write_state_valid, 1);
    chk("waddr", bus.write_addr, addr);
    chk("wstate", bus.write_state, exp);
    chk("seq_cnt", seq_error_count, exp_seq);
    chk("ready_wr", bus.packet_in_ready, 0);
    mem[addr] = exp;
    @(negedge clk);
    chk("ready_after", bus.packet_in_ready, 1);
    chk("wvalid_low", bus.write_state_valid, 0);
    chk("wstate_hold", bus.write_state, exp);
    chk("wr_strobes", wr_strobes, exp_wr);
    chk("rreq_strobes", rreq_strobes, exp_rreq);
  endtask

  task automatic rx_timeout(input int unsigned addr);
    chk("tmo_ready_c0", bus.packet_in_ready, 1);
    address = addr;
    bus.packet_in = mk_pkt(1'b1, $urandom);
    bus.packet_in_valid = 1'b1;
    @(negedge clk);
    bus.packet_in_valid = 1'b0;
    exp_rreq++;
    chk("tmo_rreq", bus.read_req, 1);
    for (int i = 1; i <= int'(TMO); i++) begin
      @(negedge clk);
      chk("tmo_ready_wait", bus.packet_in_ready, 0);
      if (i == int'(TMO)) chk("tmo_cnt_pre", timeout_count, exp_tmo);
    end
    @(negedge clk);
    exp_tmo++;
    chk("tmo_ready_back", bus.packet_in_ready, 1);
    chk("tmo_cnt", timeout_count, exp_tmo);
    bus.read_state = mem[addr];
    bus.read_state_valid = 1'b1;
    @(negedge clk);
    bus.read_state_valid = 1'b0;
    chk("tmo_no_write", wr_strobes, exp_wr);
    chk("tmo_wvalid", bus.write_state_valid, 0);
    chk("tmo_ready_late", bus.packet_in_ready, 1);
  endtask

  task automatic rx_drop(input int n);
    for (int k = 0; k < n; k++) begin
      chk("drop_ready", bus.packet_in_ready, 1);
      address = $urandom;
      bus.packet_in = mk_pkt(1'b0, $urandom);
      bus.packet_in_valid = 1'b1;
      @(negedge clk);
      exp_drop++;
      chk("drop_cnt", drop_count, exp_drop);
    end
    bus.packet_in_valid = 1'b0;
  endtask

  initial begin
    int unsigned a;
    int unsigned id;
    int          op;
    bus.packet_in = '0;
    bus.packet_in_valid = 1'b0;
    bus.read_state = '0;
    bus.read_state_valid = 1'b0;
    for (int k = 0; k < 4; k++) mem[addr_of(k)] = rand_state();

    repeat (2) @(negedge clk);
    chk("rst_ready", bus.packet_in_ready, 0);
    chk("rst_rreq", bus.read_req, 0);
    chk("rst_wvalid", bus.write_state_valid, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_seq", seq_error_count, 0);
    chk("rst_tmo", timeout_count, 0);
    chk("rst_raddr", bus.read_addr, 0);
    chk("rst_waddr", bus.write_addr, 0);
    chk("rst_wstate", bus.write_state, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_post_rst", bus.packet_in_ready, 1);

    rx_drop(5);
    chk("burst_no_rreq", rreq_strobes, 0);

    mem[addr_of(0)].user_state = 32'hABCD_0107;
    rx_pkt(addr_of(0), 7, 1, 1'b0);
    chk("inseq_word", bus.write_state.user_state, 32'h0000_0108);
    chk("inseq_seq", seq_error_count, 0);

    mem[addr_of(1)].user_state = 32'h0000_0003;
    rx_pkt(addr_of(1), 10, 1, 1'b0);
    chk("resync_word", bus.write_state.user_state, 32'd11);
    chk("resync_seq", seq_error_count, 1);

    mem[addr_of(2)].user_state = 32'h5555_00FF;
    rx_pkt(addr_of(2), 32'h1FF, 2, 1'b0);
    chk("wrap_word", bus.write_state.user_state, 32'd0);
    chk("wrap_seq", seq_error_count, 1);

    rx_pkt(addr_of(3), mem[addr_of(3)].user_state % MOD, TMO, 1'b1);

    rx_timeout(addr_of(0));

    chk("mid_ready", bus.packet_in_ready, 1);
    address = addr_of(1);
    bus.packet_in = mk_pkt(1'b1, 5);
    bus.packet_in_valid = 1'b1;
    @(negedge clk);
    bus.packet_in_valid = 1'b0;
    exp_rreq++;
    @(negedge clk);
    bus.read_state = mem[addr_of(1)];
    bus.read_state_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    bus.read_state_valid = 1'b0;
    exp_drop = 0;
    exp_seq = 0;
    exp_tmo = 0;
    chk("mid_wvalid", bus.write_state_valid, 0);
    chk("mid_rst_ready", bus.packet_in_ready, 0);
    chk("mid_drop", drop_count, 0);
    chk("mid_seq", seq_error_count, 0);
    chk("mid_tmo", timeout_count, 0);
    chk("mid_wstate", bus.write_state, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_ready_back", bus.packet_in_ready, 1);
    chk("mid_no_write", wr_strobes, exp_wr);
    rx_pkt(addr_of(1), mem[addr_of(1)].user_state % MOD, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      a = addr_of($urandom_range(0, 3));
      if (op < 3) begin
        rx_drop($urandom_range(1, 3));
      end else if (op == 3) begin
        rx_timeout(a);
      end else begin
        if ($urandom_range(0, 1) == 1)
          id = (mem[a].user_state % MOD) + MOD * $urandom_range(0, 255);
        else
          id = $urandom_range(0, 65535);
        rx_pkt(a, id, $urandom_range(1, TMO), 1'($urandom_range(0, 1)));
      end
    end
    chk("final_drop", drop_count, exp_drop);
    chk("final_seq", seq_error_count, exp_seq);
    chk("final_tmo", timeout_count, exp_tmo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
